uart_rx_reader: RTL and testbench

UART receiver that deserialises 8N1 frames from the asynchronous `rx` line into bytes. It is the receive-side counterpart of the UART transmitter: same bit timing parameters, same frame format (start 0, 8 data bits LSB first, stop 1). Each received byte is presented as a one-cycle `valid` pulse to downstream logic. Line errors are reported on a framing-error pulse.

---
 rtl/uart_rx_reader.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_reader.sv
// ---------------------------------------------------------------------------
// uart_rx_reader
//
// 8N1 UART receiver: start bit 0, eight data bits LSB first, stop bit 1.
// Each good frame produces a one-cycle `valid` pulse with the byte on `data`.
// A stop bit sampled low produces a one-cycle `frame_error` pulse. The
// receiver then waits in BREAK until the line returns high, so a line held
// low cannot be mistaken for a stream of start bits.
//
// Parameters
//   clk_mhz      system clock frequency in MHz (default 50)
//   boadrate     line bit rate (default 9600)
//
// Ports
//   clk          single clock, all logic on posedge
//   rst          asynchronous, active-low reset
//   rx           serial line, asynchronous to clk, idle high
//   data         last correctly received byte, held until the next good frame
//   valid        one-cycle pulse; data is new in that same cycle
//   busy         high whenever the FSM is not in IDLE
//   frame_error  one-cycle pulse when the stop bit samples low
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every sample is the 2-of-3 majority of
//                        rx_sync at cnt==2, cnt==1 and cnt==0 of the expiring
//                        phase (needs half >= 3). When undefined, the sample
//                        is rx_sync at cnt==0 only. Timing is identical.
// ---------------------------------------------------------------------------
module uart_rx_reader #(
  parameter int clk_mhz  = 50,
  parameter int boadrate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_error
);

  // Bit period and half bit period in clock cycles.
  localparam int scale = clk_mhz * 1000 * 1000 / boadrate;
  localparam int half  = scale / 2;

  localparam logic [31:0] scale_m1 = 32'(scale - 1);
  localparam logic [31:0] half_m1  = 32'(half - 1);

  // FSM encoding.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic sample;
  logic expire;

  // -------------------------------------------------------------------------
  // Input synchroniser and edge history. All stages reset to the idle level
  // so that leaving reset never looks like a falling edge.
  // NOTE: sequential state is assigned with <= only; blocking assignments
  // here would let later stages see this cycle's value and collapse the
  // synchroniser into a single flop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A phase ends when the down-counter reaches zero.
  assign expire = (cnt == 32'd0);

`ifdef UART_RX_MAJORITY_EN
  // Two vote registers catch rx_sync one and two cycles before expiry; the
  // third vote is rx_sync itself in the expiry cycle. A single-cycle glitch
  // on any one of the three is outvoted.
  logic vote_2;
  logic vote_1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_2 <= 1'b1;
      vote_1 <= 1'b1;
    end else begin
      if (cnt == 32'd2) vote_2 <= rx_sync;
      if (cnt == 32'd1) vote_1 <= rx_sync;
    end
  end

  assign sample = (vote_2 & vote_1) | (vote_2 & rx_sync) | (vote_1 & rx_sync);
`else
  assign sample = rx_sync;
`endif

  // -------------------------------------------------------------------------
  // Receive FSM. `valid` and `frame_error` default low every cycle so they
  // can only ever be single-cycle pulses, and they come from mutually
  // exclusive branches of the STOP decision.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 32'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      data        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        S_IDLE: begin
          // Falling edge on the synchronised line: aim the first sample at
          // the middle of the start bit.
          if (rx_prev && !rx_sync) begin
            state <= S_START;
            cnt   <= half_m1;
          end
        end

        S_START: begin
          if (expire) begin
            cnt <= scale_m1;
            if (!sample) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line was high again at mid-start: a glitch, not a frame.
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_DATA: begin
          if (expire) begin
            cnt     <= scale_m1;
            // LSB arrives first; shifting right with the new sample at bit 7
            // leaves bit 0 in shift[0] after the eighth sample.
            shift   <= {sample, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_STOP: begin
          if (expire) begin
            cnt <= scale_m1;
            if (sample) begin
              // Returning to IDLE at mid-stop re-arms the edge detector half
              // a bit early, which is what allows back-to-back frames.
              data  <= shift;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_BREAK: begin
          // Hold off until the line is released; otherwise a held-low line
          // would never produce the high-to-low edge IDLE looks for anyway,
          // but a noisy one could.
          if (rx_sync) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register, so it is glitch-free.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_reader.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_reader
//
// Directed bench for uart_rx_reader. Runs the receiver at a reduced bit
// period (1 MHz / 62500 baud -> 16 clocks per bit, half = 8) so every frame
// is short. A table of single frames is applied in a loop, followed by
// hand-written sequences for back-to-back frames, start-bit glitch, line
// break, reset mid-frame and the per-bit sample glitch.
// ---------------------------------------------------------------------------
module tb_uart_rx_reader;

  localparam int CLK_MHZ = 1;
  localparam int BAUD    = 62500;
  localparam int SCALE   = 16;
  localparam int HALF    = 8;
  localparam int LAT     = 2 + HALF + 9 * SCALE;  // E0 to the pulse cycle

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_error;

  uart_rx_reader #(
    .clk_mhz (CLK_MHZ),
    .boadrate(BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter: after posedge N, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  // Event log, sampled away from the active edge.
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_cyc[$];
  int         busy_cnt = 0;
  logic       both_seen = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data);
    end
    if (frame_error) fe_cyc.push_back(cyc);
    if (valid && frame_error) both_seen = 1'b1;
    if (busy) busy_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_log();
    v_cyc.delete();
    v_dat.delete();
    fe_cyc.delete();
  endtask

  function automatic int first_valid();
    return (v_cyc.size() > 0) ? v_cyc[0] : -1;
  endfunction

  function automatic int first_ferr();
    return (fe_cyc.size() > 0) ? fe_cyc[0] : -1;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge. e0 is the posedge that first
  // samples the start bit. With glitch set, each data bit is inverted for
  // the one cycle that reaches rx_sync exactly at that bit's cnt==0.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic glitch, output int e0);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (SCALE) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < SCALE; j++) begin
        rx = (glitch && j == HALF) ? ~b[k] : b[k];
        @(negedge clk);
      end
    end
    rx = stop_bit;
    repeat (SCALE) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop_bit;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e0;
    int e0b;
    int d;

    vecs[0] = '{tx: 8'h55, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h55};
    vecs[1] = '{tx: 8'h00, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
    vecs[2] = '{tx: 8'hFF, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};
    vecs[3] = '{tx: 8'h80, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h80};
    vecs[4] = '{tx: 8'h5A, stop_bit: 1'b0, exp_valid: 0, exp_ferr: 1, exp_data: 8'h80};
    vecs[5] = '{tx: 8'h3C, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h3C};

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ferr", frame_error, 1'b0);
    rst = 1'b1;
    idle(4);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      clear_log();
      send_frame(vecs[i].tx, vecs[i].stop_bit, 1'b0, e0);
      idle(3 * SCALE);
      check($sformatf("vec%0d_valid_cnt", i), v_cyc.size(), vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr_cnt", i), fe_cyc.size(), vecs[i].exp_ferr);
      if (vecs[i].exp_valid != 0)
        check($sformatf("vec%0d_valid_cyc", i), first_valid(), e0 + LAT);
      if (vecs[i].exp_ferr != 0)
        check($sformatf("vec%0d_ferr_cyc", i), first_ferr(), e0 + LAT);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
    end

    // Back-to-back frames with no idle time between them.
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0, e0);
    send_frame(8'h3C, 1'b1, 1'b0, e0b);
    idle(3 * SCALE);
    check("b2b_valid_cnt", v_cyc.size(), 2);
    check("b2b_first_cyc", first_valid(), e0 + LAT);
    check("b2b_spacing", (v_cyc.size() == 2) ? v_cyc[1] - v_cyc[0] : -1, 10 * SCALE);
    check("b2b_data0", (v_dat.size() > 0) ? v_dat[0] : 8'hxx, 8'hA5);
    check("b2b_data1", (v_dat.size() > 1) ? v_dat[1] : 8'hxx, 8'h3C);
    check("b2b_ferr_cnt", fe_cyc.size(), 0);

    // Short low pulse: START for half a bit, then back to IDLE silently.
    clear_log();
    busy_cnt = 0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(3 * SCALE);
    check("glitch_busy_cycles", busy_cnt, HALF);
    check("glitch_valid_cnt", v_cyc.size(), 0);
    check("glitch_ferr_cnt", fe_cyc.size(), 0);
    check("glitch_data", data, 8'h3C);

    // Line break: held low for 20 bit times.
    clear_log();
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (20 * SCALE) @(negedge clk);
    check("break_busy_held", busy, 1'b1);
    rx = 1'b1;
    d = cyc;
    repeat (2) @(negedge clk);
    check("break_busy_before_release", (cyc == d + 2) ? busy : 1'bx, 1'b1);
    @(negedge clk);
    check("break_busy_dropped", busy, 1'b0);
    check("break_ferr_cnt", fe_cyc.size(), 1);
    check("break_ferr_cyc", first_ferr(), e0 + LAT);
    check("break_valid_cnt", v_cyc.size(), 0);
    check("break_data_kept", data, 8'h3C);
    idle(2 * SCALE);
    clear_log();
    send_frame(8'h81, 1'b1, 1'b0, e0);
    idle(3 * SCALE);
    check("after_break_valid_cnt", v_cyc.size(), 1);
    check("after_break_valid_cyc", first_valid(), e0 + LAT);
    check("after_break_data", data, 8'h81);

    // Reset asserted in the middle of data bit 4.
    rx = 1'b0;
    repeat (SCALE) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx = k[0];
      repeat (SCALE) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_flags", {valid, busy, frame_error}, 3'b000);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2 * SCALE);
    clear_log();
    send_frame(8'hC3, 1'b1, 1'b0, e0);
    idle(3 * SCALE);
    check("after_rst_valid_cnt", v_cyc.size(), 1);
    check("after_rst_valid_cyc", first_valid(), e0 + LAT);
    check("after_rst_data", data, 8'hC3);

    // One-cycle inverted glitch on every data bit, timed at cnt==0.
    clear_log();
    send_frame(8'h96, 1'b1, 1'b1, e0);
    idle(3 * SCALE);
    check("sample_glitch_valid_cnt", v_cyc.size(), 1);
`ifdef UART_RX_MAJORITY_EN
    check("sample_glitch_data", data, 8'h96);
`else
    check("sample_glitch_data", data, 8'h69);
`endif

    check("valid_and_ferr_exclusive", both_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
